// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, shifts
// one command byte plus odd parity on device clock falls, then reports ACK/NACK/timeout.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    // The REQ cycle still holds the clock low, so INHIBIT itself lasts one cycle less.
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [8:0]             shift_q, shift_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]          inh_cnt_q, inh_cnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic                   ack_ok_q, ack_ok_d;
    logic                   clk_oe_q, clk_oe_d;
    logic                   dat_oe_q, dat_oe_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;

    logic clk_s, dat_s, fe, accept, timeout, lines_idle;

    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign dat_s      = dat_sync_q[SYNC_STAGES-1];
    assign fe         = clk_prev_q & ~clk_s;
    assign accept     = tx_valid & (state_q == IDLE);
    assign timeout    = (to_cnt_q == '0) & ~fe;
    assign lines_idle = clk_s & dat_s;

    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE) | done_q | error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign done       = done_q;
    assign error      = error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            ack_ok_q   <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            ack_ok_q   <= ack_ok_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_in};
            clk_prev_q <= clk_s;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (accept) state_d = INHIBIT;
            INHIBIT:   if (inh_cnt_q == INH_LAST) state_d = REQ;
            REQ:       state_d = SHIFT;
            SHIFT:     if (fe && bit_cnt_q == 4'd9) state_d = ACK;
                       else if (timeout) state_d = IDLE;
            ACK:       if (fe) state_d = WAIT_IDLE;
                       else if (timeout) state_d = IDLE;
            WAIT_IDLE: if (lines_idle || timeout) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (accept) begin
                    shift_d   = {~^tx_data, tx_data};
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                end
            end
            INHIBIT: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                if (inh_cnt_q == INH_LAST) dat_oe_d = 1'b1;
            end
            REQ: begin
                clk_oe_d = 1'b0;
                to_cnt_d = TO_LOAD;
            end
            SHIFT: begin
                if (fe) begin
                    to_cnt_d = TO_LOAD;
                    if (bit_cnt_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                    end else begin
                        dat_oe_d  = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (timeout) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            ACK: begin
                if (fe) begin
                    ack_ok_d = ~dat_s;
                    to_cnt_d = TO_LOAD;
                end else if (timeout) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (lines_idle) begin
                    done_d  = ack_ok_q;
                    error_d = ~ack_ok_q;
                end else if (timeout) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                end else if (fe) begin
                    to_cnt_d = TO_LOAD;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT and compares
// captured bits, pulses and line state against a byte-level frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 2000;
    localparam int HP  = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, done, error;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] acc_q[$];

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy(busy),
        .done(done),
        .error(error)
    );

    // Open-drain wired-AND of host and device on each line
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)  done_cnt++;
        if (error) err_cnt++;
    end

    always @(posedge clk) begin
        if (!reset && tx_valid && tx_ready) acc_q.push_back(tx_data);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Wire-level frame as a device sees it: start, data LSB first, odd parity, stop
    function automatic logic [10:0] expect_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input logic [7:0] b);
        int w = 0;
        while (!tx_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic nack, output logic [10:0] cap,
                             output int inh_len, output bit ok);
        int w = 0;
        ok = 1'b1;
        cap = '0;
        inh_len = 0;
        while (!ps2_clk_oe && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!ps2_clk_oe) begin
            ok = 1'b0;
            return;
        end
        while (ps2_clk_oe && inh_len < 200) begin
            inh_len++;
            @(negedge clk);
        end
        cyc(HP);
        cap[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            cyc(HP);
            dev_clk = 1'b1;
            cap[k] = ps2_dat_in;
            cyc(HP);
        end
        if (!nack) dev_dat = 1'b0;
        cyc(5);
        dev_clk = 1'b0;
        cyc(HP);
        dev_clk = 1'b1;
        cyc(5);
        dev_dat = 1'b1;
        w = 0;
        while (!(done || error) && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!(done || error)) ok = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe, done, error} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_state: got %b expected 100000", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe, done, error});
        end
        offer(8'hA5);
        cyc(5);
        checks++;
        if (ps2_clk_oe !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_inhibit_setup: got clk_oe=%b busy=%b expected 1 1", ps2_clk_oe, busy);
        end
        reset = 1'b1;
        cyc(1);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got clk_oe=%b dat_oe=%b expected 0 0", ps2_clk_oe, ps2_dat_oe);
        end
        cyc(2);
        reset = 1'b0;
        cyc(1);
        checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_after: got %b expected 1000", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_frame(input logic [7:0] b);
        logic [10:0] cap;
        int          inh_len;
        bit          ok;
        int          d0 = done_cnt;
        int          e0 = err_cnt;
        offer(b);
        checks++;
        if (busy !== 1'b1 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL frame_busy %h: got busy=%b ready=%b expected 1 0", b, busy, tx_ready);
        end
        run_frame(1'b0, cap, inh_len, ok);
        cyc(2);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_handshake %h: got no completion expected done/error pulse", b);
        end
        checks++;
        if (inh_len !== INH) begin
            errors++;
            $display("FAIL frame_inhibit %h: got %0d cycles expected %0d", b, inh_len, INH);
        end
        checks++;
        if (cap !== expect_frame(b)) begin
            errors++;
            $display("FAIL frame_bits %h: got %b expected %b", b, cap, expect_frame(b));
        end
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL frame_pulses %h: got done=%0d err=%0d expected 1 0", b, done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
            errors++;
            $display("FAIL frame_idle %h: got %b expected 1000", b, {tx_ready, busy, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_nack;
        logic [10:0] cap;
        int          inh_len;
        bit          ok;
        logic [7:0]  b = 8'($urandom_range(0, 255));
        int          d0 = done_cnt;
        int          e0 = err_cnt;
        offer(b);
        run_frame(1'b1, cap, inh_len, ok);
        cyc(2);
        checks++;
        if (cap !== expect_frame(b)) begin
            errors++;
            $display("FAIL nack_bits %h: got %b expected %b", b, cap, expect_frame(b));
        end
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL nack_pulses: got done=%0d err=%0d expected 0 1", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({tx_ready, ps2_clk_oe, ps2_dat_oe} !== 3'b100) begin
            errors++;
            $display("FAIL nack_idle: got %b expected 100", {tx_ready, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_timeout;
        int w = 0;
        int n = 0;
        int e0 = err_cnt;
        int d0 = done_cnt;
        offer(8'h3C);
        while (!ps2_dat_oe && w < 100) begin
            @(negedge clk);
            w++;
        end
        while (!error && n < TO + 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < TO - 1 || n > TO + 1) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TO);
        end
        checks++;
        if ({tx_ready, ps2_clk_oe, ps2_dat_oe} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_release: got %b expected 100", {tx_ready, ps2_clk_oe, ps2_dat_oe});
        end
        cyc(2);
        checks++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL timeout_pulses: got err=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] cap1, cap2;
        int          inh_len;
        bit          ok1, ok2;
        int          d0 = done_cnt;
        int          w = 0;
        acc_q.delete();
        while (!tx_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'h55;
        run_frame(1'b0, cap1, inh_len, ok1);
        @(negedge clk);
        tx_valid = 1'b0;
        run_frame(1'b0, cap2, inh_len, ok2);
        cyc(2);
        checks++;
        if (!ok1 || !ok2 || cap1 !== expect_frame(8'hFF)) begin
            errors++;
            $display("FAIL b2b_first: got %b expected %b", cap1, expect_frame(8'hFF));
        end
        checks++;
        if (cap2 !== expect_frame(8'h55)) begin
            errors++;
            $display("FAIL b2b_second: got %b expected %b", cap2, expect_frame(8'h55));
        end
        checks++;
        if (acc_q.size() != 2 || done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d accepts %0d done expected 2 2", acc_q.size(), done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hF4);
        test_frame(8'hED);
        test_frame(8'h00);
        for (int i = 0; i < 4; i++) test_frame(8'($urandom_range(0, 255)));
        test_nack();
        test_timeout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
